// File: rtl/init_cordic_stream.sv
// CORDIC seed stage: builds four gain-compensated polygon vertices, applies a quadrant
// pre-rotation and queues vertices, residual angle and sideband in a ready/valid FIFO.
module init_cordic_stream #(
    parameter int unsigned SIZE_W  = 7,
    parameter int unsigned COORD_W = 19,
    parameter int unsigned ANGLE_W = 9,
    parameter int unsigned SIDE_W  = 48,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIZE_W-1:0]  in_size,
    input  logic [ANGLE_W-1:0] in_angle,
    input  logic [1:0]         in_form,
    input  logic [SIDE_W-1:0]  in_side,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_v1_x,
    output logic [COORD_W-1:0] out_v1_y,
    output logic [COORD_W-1:0] out_v2_x,
    output logic [COORD_W-1:0] out_v2_y,
    output logic [COORD_W-1:0] out_v3_x,
    output logic [COORD_W-1:0] out_v3_y,
    output logic [COORD_W-1:0] out_v4_x,
    output logic [COORD_W-1:0] out_v4_y,
    output logic [ANGLE_W-1:0] out_angle,
    output logic               out_enable,
    output logic [SIDE_W-1:0]  out_side
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned C      = COORD_W;
    localparam int unsigned VERT_W = 8 * COORD_W;
    localparam logic [CNT_W-1:0]   FULL    = CNT_W'(DEPTH);
    localparam logic [ANGLE_W-1:0] QUARTER = ANGLE_W'(1 << (ANGLE_W - 2));

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             push, pop;

    logic [C-1:0]       b, p, n;
    logic [C-1:0]       bx [4];
    logic [C-1:0]       by [4];
    logic [C-1:0]       rx [4];
    logic [C-1:0]       ry [4];
    logic [ANGLE_W-1:0] residual;
    logic [VERT_W-1:0]  vert_w;

    logic [VERT_W-1:0]  mem_vert  [DEPTH];
    logic [ANGLE_W-1:0] mem_angle [DEPTH];
    logic               mem_en    [DEPTH];
    logic [SIDE_W-1:0]  mem_side  [DEPTH];
    logic [VERT_W-1:0]  head_vert;

    // Handshake flags come from the count register; reset gating keeps both low during reset.
    assign in_ready  = reset && (count_q != FULL);
    assign out_valid = reset && (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Gain compensation approximates 0.607 * size with shift-adds.
    always_comb begin
        b = C'(in_size);
        p = (b >> 1) + (b >> 4) + (b >> 5) + (b >> 7) + (b >> 8);
        n = -p;
        bx[0] = n;  by[0] = n;
        bx[1] = n;  by[1] = p;
        bx[2] = p;  by[2] = p;
        bx[3] = p;  by[3] = n;
        case (in_form)
            2'd1: begin
                bx[0] = '0; by[0] = n;
                bx[1] = n;  by[1] = p;
                bx[2] = p;  by[2] = p;
                bx[3] = '0; by[3] = '0;
            end
            2'd2: begin
                bx[0] = '0; by[0] = n;
                bx[1] = n;  by[1] = '0;
                bx[2] = '0; by[2] = p;
                bx[3] = p;  by[3] = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        residual = in_angle;
        vert_w   = '0;
        for (int k = 0; k < 4; k++) begin
            rx[k] = bx[k];
            ry[k] = by[k];
        end
        unique case (in_angle[ANGLE_W-1 -: 2])
            2'b01: begin
                residual = in_angle - QUARTER;
                for (int k = 0; k < 4; k++) begin
                    rx[k] = -by[k];
                    ry[k] = bx[k];
                end
            end
            2'b10: begin
                residual = in_angle + QUARTER;
                for (int k = 0; k < 4; k++) begin
                    rx[k] = by[k];
                    ry[k] = -bx[k];
                end
            end
            default: ;
        endcase
        for (int k = 0; k < 4; k++) begin
            vert_w[(8 - 2 * k) * C - 1 -: C] = rx[k];
            vert_w[(7 - 2 * k) * C - 1 -: C] = ry[k];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_vert[wr_ptr_q]  <= vert_w;
            mem_angle[wr_ptr_q] <= residual;
            mem_en[wr_ptr_q]    <= (residual != '0);
            mem_side[wr_ptr_q]  <= in_side;
        end
    end

    assign head_vert = mem_vert[rd_ptr_q];

    always_comb begin
        out_v1_x   = '0;
        out_v1_y   = '0;
        out_v2_x   = '0;
        out_v2_y   = '0;
        out_v3_x   = '0;
        out_v3_y   = '0;
        out_v4_x   = '0;
        out_v4_y   = '0;
        out_angle  = '0;
        out_enable = 1'b0;
        out_side   = '0;
        if (out_valid) begin
            out_v1_x   = head_vert[8 * C - 1 -: C];
            out_v1_y   = head_vert[7 * C - 1 -: C];
            out_v2_x   = head_vert[6 * C - 1 -: C];
            out_v2_y   = head_vert[5 * C - 1 -: C];
            out_v3_x   = head_vert[4 * C - 1 -: C];
            out_v3_y   = head_vert[3 * C - 1 -: C];
            out_v4_x   = head_vert[2 * C - 1 -: C];
            out_v4_y   = head_vert[C - 1 -: C];
            out_angle  = mem_angle[rd_ptr_q];
            out_enable = mem_en[rd_ptr_q];
            out_side   = mem_side[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_init_cordic_stream.sv
// Bench for init_cordic_stream: directed and random requests scored against a queue model
// that computes vertices and residual angles with plain integer arithmetic.
module tb_init_cordic_stream;

    localparam int SIZE_W  = 7;
    localparam int COORD_W = 19;
    localparam int ANGLE_W = 9;
    localparam int SIDE_W  = 48;
    localparam int DEPTH   = 2;

    typedef struct {
        int               vx[4];
        int               vy[4];
        int               res;
        bit               en;
        logic [SIDE_W-1:0] side;
    } entry_t;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [SIZE_W-1:0]  in_size;
    logic [ANGLE_W-1:0] in_angle;
    logic [1:0]         in_form;
    logic [SIDE_W-1:0]  in_side;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] got_x [4];
    logic [COORD_W-1:0] got_y [4];
    logic [ANGLE_W-1:0] out_angle;
    logic               out_enable;
    logic [SIDE_W-1:0]  out_side;

    entry_t exp_q[$];
    int     n_compared;
    int     n_mismatched;

    init_cordic_stream #(
        .SIZE_W (SIZE_W),
        .COORD_W(COORD_W),
        .ANGLE_W(ANGLE_W),
        .SIDE_W (SIDE_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_size   (in_size),
        .in_angle  (in_angle),
        .in_form   (in_form),
        .in_side   (in_side),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v1_x  (got_x[0]),
        .out_v1_y  (got_y[0]),
        .out_v2_x  (got_x[1]),
        .out_v2_y  (got_y[1]),
        .out_v3_x  (got_x[2]),
        .out_v3_y  (got_y[2]),
        .out_v4_x  (got_x[3]),
        .out_v4_y  (got_y[3]),
        .out_angle (out_angle),
        .out_enable(out_enable),
        .out_side  (out_side)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 0.607*size via integer division, then quarter-turn by angle range.
    function automatic entry_t model(input int sz, input int ang, input int fm,
                                     input logic [SIDE_W-1:0] sd);
        entry_t e;
        int p, n;
        int bx[4];
        int by[4];
        p = sz / 2 + sz / 16 + sz / 32 + sz / 128 + sz / 256;
        n = -p;
        case (fm)
            1: begin bx = '{0, n, p, 0}; by = '{n, p, p, 0}; end
            2: begin bx = '{0, n, 0, p}; by = '{n, 0, p, 0}; end
            default: begin bx = '{n, n, p, p}; by = '{n, p, p, n}; end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (ang >= 128) begin
                e.vx[i] = -by[i]; e.vy[i] = bx[i];
            end else if (ang < -128) begin
                e.vx[i] = by[i];  e.vy[i] = -bx[i];
            end else begin
                e.vx[i] = bx[i];  e.vy[i] = by[i];
            end
        end
        e.res  = (ang >= 128) ? ang - 128 : (ang < -128) ? ang + 128 : ang;
        e.en   = (e.res != 0);
        e.side = sd;
        return e;
    endfunction

    task automatic check_outputs();
        entry_t e;
        bit     nonempty;
        logic [COORD_W-1:0] cx, cy;
        logic [ANGLE_W-1:0] ca;
        nonempty = (exp_q.size() != 0);
        check_value("out_valid", 64'(out_valid), 64'(nonempty));
        check_value("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
        if (nonempty) begin
            e = exp_q[0];
        end else begin
            for (int i = 0; i < 4; i++) begin e.vx[i] = 0; e.vy[i] = 0; end
            e.res = 0; e.en = 1'b0; e.side = '0;
        end
        for (int i = 0; i < 4; i++) begin
            cx = COORD_W'(e.vx[i]);
            cy = COORD_W'(e.vy[i]);
            check_value($sformatf("v%0d_x", i + 1), 64'(got_x[i]), 64'(cx));
            check_value($sformatf("v%0d_y", i + 1), 64'(got_y[i]), 64'(cy));
        end
        ca = ANGLE_W'(e.res);
        check_value("out_angle", 64'(out_angle), 64'(ca));
        check_value("out_enable", 64'(out_enable), 64'(e.en));
        check_value("out_side", 64'(out_side), 64'(e.side));
    endtask

    // Called #1 after a rising edge; drives one cycle of inputs and scores the result.
    task automatic step(input bit v, input int sz, input int ang, input int fm,
                        input logic [SIDE_W-1:0] sd, input bit ordy, output bit acc);
        bit pop;
        in_valid  = v;
        in_size   = SIZE_W'(sz);
        in_angle  = ANGLE_W'(ang);
        in_form   = 2'(fm);
        in_side   = sd;
        out_ready = ordy;
        acc = v && (exp_q.size() != DEPTH);
        pop = ordy && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) exp_q.delete(0);
        if (acc) exp_q.push_back(model(sz, ang, fm, sd));
        check_outputs();
    endtask

    task automatic send(input int sz, input int ang, input int fm,
                        input logic [SIDE_W-1:0] sd, input bit ordy);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) step(1'b1, sz, ang, fm, sd, ordy, acc);
        check_value("accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int cycles, input bit ordy);
        bit acc;
        for (int t = 0; t < cycles; t++) step(1'b0, 0, 0, 0, '0, ordy, acc);
    endtask

    function automatic logic [SIDE_W-1:0] rand_side();
        return {16'($urandom), $urandom};
    endfunction

    initial begin
        bit acc;
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_size   = '0;
        in_angle  = '0;
        in_form   = '0;
        in_side   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_out_valid", 64'(out_valid), 64'(0));
        check_value("rst_in_ready", 64'(in_ready), 64'(0));
        check_value("rst_v1_x", 64'(got_x[0]), 64'(0));
        reset = 1'b1;
        #1;
        check_outputs();

        // Directed shapes and quadrant boundaries.
        send(100, 0, 0, 48'h0000_0000_00A1, 1'b1);
        send(100, 150, 0, 48'h0000_0000_00A2, 1'b1);
        send(100, -150, 1, 48'h0000_0000_00A3, 1'b1);
        send(100, 128, 0, 48'h0000_0000_00A4, 1'b1);
        send(100, -128, 0, 48'h0000_0000_00A5, 1'b1);
        send(100, -256, 0, 48'h0000_0000_00A6, 1'b1);
        send(127, 255, 2, 48'hFFFF_FFFF_FFFF, 1'b1);
        send(77, -129, 3, 48'h1234_5678_9ABC, 1'b1);
        idle(2, 1'b1);

        // Back-pressure: two fill the FIFO, the third waits while the head stays put.
        send(10, 20, 0, 48'h0000_0000_0B01, 1'b0);
        send(20, 140, 1, 48'h0000_0000_0B02, 1'b0);
        for (int t = 0; t < 3; t++) step(1'b1, 30, -200, 2, 48'h0000_0000_0B03, 1'b0, acc);
        send(30, -200, 2, 48'h0000_0000_0B03, 1'b1);
        idle(4, 1'b1);

        // Streaming, then a reset with two entries queued.
        for (int t = 0; t < 20; t++)
            step(1'b1, $urandom_range(0, 127), int'($urandom_range(0, 511)) - 256,
                 $urandom_range(0, 3), rand_side(), 1'b1, acc);
        step(1'b1, 5, 5, 0, 48'h0000_0000_0C01, 1'b0, acc);
        step(1'b1, 6, 6, 1, 48'h0000_0000_0C02, 1'b0, acc);
        check_value("pre_reset_full", 64'(exp_q.size()), 64'(DEPTH));
        reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_value("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check_value("mid_rst_in_ready", 64'(in_ready), 64'(0));
        check_value("mid_rst_side", 64'(out_side), 64'(0));
        @(posedge clk);
        #1;
        exp_q.delete();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_outputs();

        // Random traffic with random back-pressure.
        for (int t = 0; t < 400; t++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 127),
                 int'($urandom_range(0, 511)) - 256, $urandom_range(0, 3), rand_side(),
                 $urandom_range(0, 2) != 0, acc);
        idle(4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
